// File: rtl/bb8051_dptr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bb8051_dptr_ctrl_pkg
// Shared definitions for the DPTR sequencer: SFR action codes understood by
// the DPTR register block, DPTR reset bytes, the command codes issued by the
// core decoder and the sequencer state encoding.
// ---------------------------------------------------------------------------
package bb8051_dptr_ctrl_pkg;

    // Action codes understood by the DPTR register block
    localparam logic [1:0] BB8051_SFR_ACT_NONE    = 2'b00;
    localparam logic [1:0] BB8051_SFR_ACT_WR_BYTE = 2'b01;

    // DPTR contents after reset
    localparam logic [7:0] BB8051_RST_DPH = 8'h00;
    localparam logic [7:0] BB8051_RST_DPL = 8'h00;

    // Commands from the core decoder
    typedef enum logic [2:0] {
        BB8051_DPC_NOP     = 3'd0,
        BB8051_DPC_LOAD16  = 3'd1,
        BB8051_DPC_INC     = 3'd2,
        BB8051_DPC_WR_DPH  = 3'd3,
        BB8051_DPC_WR_DPL  = 3'd4,
        BB8051_DPC_MOVX_RD = 3'd5,
        BB8051_DPC_MOVX_WR = 3'd6,
        BB8051_DPC_MOVC    = 3'd7
    } dpc_cmd_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_XREQ = 2'd2,
        ST_FIN  = 2'd3
    } dpc_state_e;

endpackage

// File: rtl/bb8051_dptr_ctrl_if.sv
// ---------------------------------------------------------------------------
// bb8051_dptr_ctrl_if
// External memory request/acknowledge bus used for MOVX and MOVC transfers.
//   xmem_addr  : 16-bit external address
//   xmem_rd    : read strobe, held until ack or timeout
//   xmem_wr    : write strobe, held until ack or timeout
//   xmem_wdata : write data
//   xmem_rdata : read data, valid together with xmem_ack
//   xmem_ack   : transfer complete
// master = the DPTR sequencer, slave = the memory side.
// ---------------------------------------------------------------------------
interface bb8051_dptr_ctrl_if;
    logic [15:0] xmem_addr;
    logic        xmem_rd;
    logic        xmem_wr;
    logic [7:0]  xmem_wdata;
    logic [7:0]  xmem_rdata;
    logic        xmem_ack;

    modport master (
        output xmem_addr, xmem_rd, xmem_wr, xmem_wdata,
        input  xmem_rdata, xmem_ack
    );

    modport slave (
        input  xmem_addr, xmem_rd, xmem_wr, xmem_wdata,
        output xmem_rdata, xmem_ack
    );
endinterface

// File: rtl/bb8051_dptr_ctrl_addgen.sv
// ---------------------------------------------------------------------------
// bb8051_dptr_addgen
// Combinational DPTR address arithmetic shared by INC and MOVC.
//   i_dptr     : current DPTR
//   i_acc      : accumulator (MOVC offset)
//   o_dptr_inc : DPTR + 1, wraps FFFF -> 0000
//   o_dptr_acc : DPTR + acc, carry out of bit 15 discarded
// ---------------------------------------------------------------------------
module bb8051_dptr_addgen (
    input  logic [15:0] i_dptr,
    input  logic [7:0]  i_acc,
    output logic [15:0] o_dptr_inc,
    output logic [15:0] o_dptr_acc
);

    // Both sums are kept at 16 bits so the carry simply falls off the top
    assign o_dptr_inc = i_dptr + 16'd1;
    assign o_dptr_acc = i_dptr + {8'h00, i_acc};

endmodule

// File: rtl/bb8051_dptr_ctrl.sv
// ---------------------------------------------------------------------------
// bb8051_dptr_ctrl
// Sequencer in front of the DPTR register block. Turns single-cycle decoder
// commands into DPTR writes and performs DPTR-addressed external memory
// transfers with a bounded wait. Only writer of the DPTR block.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_cmd_valid/i_cmd     : command strobe and code (taken only when ready)
//   i_cmd_imm             : immediate / MOVX write data in [7:0]
//   i_acc                 : accumulator, MOVC offset
//   o_cmd_ready           : high in IDLE
//   o_done / o_err        : completion pulse / timeout flag with done
//   o_rd_data             : last external read byte
//   i_dptr_in_h/l         : current DPTR from the register block
//   o_sfr_action          : DPTR block action
//   o_wr_data_h/l         : DPTR block write data
//   xmem                  : external memory bus (master side)
// ---------------------------------------------------------------------------
module bb8051_dptr_ctrl
    import bb8051_dptr_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd,
    input  logic [15:0] i_cmd_imm,
    input  logic [7:0]  i_acc,
    output logic        o_cmd_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [7:0]  o_rd_data,
    input  logic [7:0]  i_dptr_in_h,
    input  logic [7:0]  i_dptr_in_l,
    output logic [1:0]  o_sfr_action,
    output logic [7:0]  o_wr_data_h,
    output logic [7:0]  o_wr_data_l,
    bb8051_dptr_ctrl_if.master xmem
);

    dpc_state_e r_state;
    dpc_state_e w_stateNext;

    logic             r_cmdReady;
    logic             r_done;
    logic             r_err;
    logic [7:0]       r_rdData;
    logic [1:0]       r_sfrAction;
    logic [15:0]      r_wrData;
    logic [15:0]      r_xmemAddr;
    logic             r_xmemRd;
    logic             r_xmemWr;
    logic [7:0]       r_xmemWdata;
    logic [CNT_W-1:0] r_waitCnt;

    logic             w_doneNext;
    logic             w_errNext;
    logic [7:0]       w_rdDataNext;
    logic [1:0]       w_sfrActionNext;
    logic [15:0]      w_wrDataNext;
    logic [15:0]      w_xmemAddrNext;
    logic             w_xmemRdNext;
    logic             w_xmemWrNext;
    logic [7:0]       w_xmemWdataNext;
    logic [CNT_W-1:0] w_waitCntNext;

    logic [15:0]      w_dptr;
    logic [15:0]      w_dptrInc;
    logic [15:0]      w_dptrAcc;

    assign w_dptr = {i_dptr_in_h, i_dptr_in_l};

    bb8051_dptr_addgen u_addgen (
        .i_dptr     (w_dptr),
        .i_acc      (i_acc),
        .o_dptr_inc (w_dptrInc),
        .o_dptr_acc (w_dptrAcc)
    );

    // State register; reset always returns to IDLE, abandoning any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle later: e.g. the DPTR write for a
    // register command is prepared on the acceptance edge and is visible
    // during the UPD cycle. The wait counter is loaded with 1 on acceptance
    // so that it equals the number of cycles the strobe has been held.
    always_comb begin
        w_stateNext     = r_state;
        w_doneNext      = 1'b0;
        w_errNext       = 1'b0;
        w_rdDataNext    = r_rdData;
        w_sfrActionNext = BB8051_SFR_ACT_NONE;
        w_wrDataNext    = r_wrData;
        w_xmemAddrNext  = r_xmemAddr;
        w_xmemRdNext    = r_xmemRd;
        w_xmemWrNext    = r_xmemWr;
        w_xmemWdataNext = r_xmemWdata;
        w_waitCntNext   = r_waitCnt;

        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    case (i_cmd)
                        BB8051_DPC_LOAD16: begin
                            w_stateNext     = ST_UPD;
                            w_sfrActionNext = BB8051_SFR_ACT_WR_BYTE;
                            w_wrDataNext    = i_cmd_imm;
                            w_doneNext      = 1'b1;
                        end
                        BB8051_DPC_INC: begin
                            w_stateNext     = ST_UPD;
                            w_sfrActionNext = BB8051_SFR_ACT_WR_BYTE;
                            w_wrDataNext    = w_dptrInc;
                            w_doneNext      = 1'b1;
                        end
                        // The DPTR block always writes both bytes, so the
                        // untouched byte is written back with its own value
                        BB8051_DPC_WR_DPH: begin
                            w_stateNext     = ST_UPD;
                            w_sfrActionNext = BB8051_SFR_ACT_WR_BYTE;
                            w_wrDataNext    = {i_cmd_imm[7:0], i_dptr_in_l};
                            w_doneNext      = 1'b1;
                        end
                        BB8051_DPC_WR_DPL: begin
                            w_stateNext     = ST_UPD;
                            w_sfrActionNext = BB8051_SFR_ACT_WR_BYTE;
                            w_wrDataNext    = {i_dptr_in_h, i_cmd_imm[7:0]};
                            w_doneNext      = 1'b1;
                        end
                        BB8051_DPC_MOVX_RD: begin
                            w_stateNext    = ST_XREQ;
                            w_xmemAddrNext = w_dptr;
                            w_xmemRdNext   = 1'b1;
                            w_waitCntNext  = CNT_W'(1);
                        end
                        BB8051_DPC_MOVX_WR: begin
                            w_stateNext     = ST_XREQ;
                            w_xmemAddrNext  = w_dptr;
                            w_xmemWrNext    = 1'b1;
                            w_xmemWdataNext = i_cmd_imm[7:0];
                            w_waitCntNext   = CNT_W'(1);
                        end
                        BB8051_DPC_MOVC: begin
                            w_stateNext    = ST_XREQ;
                            w_xmemAddrNext = w_dptrAcc;
                            w_xmemRdNext   = 1'b1;
                            w_waitCntNext  = CNT_W'(1);
                        end
                        default: begin
                            w_stateNext = ST_FIN;
                            w_doneNext  = 1'b1;
                        end
                    endcase
                end
            end

            ST_UPD: begin
                w_stateNext = ST_IDLE;
            end

            // Ack takes priority over the timeout check, so an ack landing
            // in the last allowed cycle still completes successfully
            ST_XREQ: begin
                if (xmem.xmem_ack) begin
                    w_xmemRdNext = 1'b0;
                    w_xmemWrNext = 1'b0;
                    if (r_xmemRd) begin
                        w_rdDataNext = xmem.xmem_rdata;
                    end
                    w_stateNext = ST_FIN;
                    w_doneNext  = 1'b1;
                end else if (r_waitCnt == CNT_W'(WAIT_MAX)) begin
                    w_xmemRdNext = 1'b0;
                    w_xmemWrNext = 1'b0;
                    if (r_xmemRd) begin
                        w_rdDataNext = 8'hFF;
                    end
                    w_stateNext = ST_FIN;
                    w_doneNext  = 1'b1;
                    w_errNext   = 1'b1;
                end else begin
                    w_waitCntNext = r_waitCnt + CNT_W'(1);
                end
            end

            ST_FIN: begin
                w_stateNext = ST_IDLE;
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Output registers; reset clears strobes immediately so an interrupted
    // transfer never produces a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmdReady  <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdData    <= 8'h00;
            r_sfrAction <= BB8051_SFR_ACT_NONE;
            r_wrData    <= 16'h0000;
            r_xmemAddr  <= 16'h0000;
            r_xmemRd    <= 1'b0;
            r_xmemWr    <= 1'b0;
            r_xmemWdata <= 8'h00;
            r_waitCnt   <= '0;
        end else begin
            r_cmdReady  <= (w_stateNext == ST_IDLE);
            r_done      <= w_doneNext;
            r_err       <= w_errNext;
            r_rdData    <= w_rdDataNext;
            r_sfrAction <= w_sfrActionNext;
            r_wrData    <= w_wrDataNext;
            r_xmemAddr  <= w_xmemAddrNext;
            r_xmemRd    <= w_xmemRdNext;
            r_xmemWr    <= w_xmemWrNext;
            r_xmemWdata <= w_xmemWdataNext;
            r_waitCnt   <= w_waitCntNext;
        end
    end

    assign o_cmd_ready     = r_cmdReady;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_rd_data       = r_rdData;
    assign o_sfr_action    = r_sfrAction;
    assign o_wr_data_h     = r_wrData[15:8];
    assign o_wr_data_l     = r_wrData[7:0];
    assign xmem.xmem_addr  = r_xmemAddr;
    assign xmem.xmem_rd    = r_xmemRd;
    assign xmem.xmem_wr    = r_xmemWr;
    assign xmem.xmem_wdata = r_xmemWdata;

endmodule

// File: tb/tb_bb8051_dptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bb8051_dptr_ctrl
// Testbench for bb8051_dptr_ctrl. Contains a simple DPTR register block, an
// external memory responder with programmable ack delay, a reference model
// that predicts each command's result, and a scoreboard monitor.
// ---------------------------------------------------------------------------
module tb_bb8051_dptr_ctrl;
    import bb8051_dptr_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;
    localparam int NEVER    = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_cmd_valid;
    logic [2:0]  i_cmd;
    logic [15:0] i_cmd_imm;
    logic [7:0]  i_acc;
    logic        o_cmd_ready;
    logic        o_done;
    logic        o_err;
    logic [7:0]  o_rd_data;
    logic [7:0]  i_dptr_in_h;
    logic [7:0]  i_dptr_in_l;
    logic [1:0]  o_sfr_action;
    logic [7:0]  o_wr_data_h;
    logic [7:0]  o_wr_data_l;

    bb8051_dptr_ctrl_if xmemIf ();

    bb8051_dptr_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .i_cmd_imm    (i_cmd_imm),
        .i_acc        (i_acc),
        .o_cmd_ready  (o_cmd_ready),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_rd_data    (o_rd_data),
        .i_dptr_in_h  (i_dptr_in_h),
        .i_dptr_in_l  (i_dptr_in_l),
        .o_sfr_action (o_sfr_action),
        .o_wr_data_h  (o_wr_data_h),
        .o_wr_data_l  (o_wr_data_l),
        .xmem         (xmemIf)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance-to-done latency
    int cycleNo = 0;
    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Stand-in for the DPTR register block: loads both bytes on WR_BYTE
    logic [15:0] dptrReg;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dptrReg <= {BB8051_RST_DPH, BB8051_RST_DPL};
        else if (o_sfr_action == BB8051_SFR_ACT_WR_BYTE) dptrReg <= {o_wr_data_h, o_wr_data_l};
    end
    assign i_dptr_in_h = dptrReg[15:8];
    assign i_dptr_in_l = dptrReg[7:0];

    typedef struct {
        bit          isReg;
        bit          isXmem;
        bit          isWrite;
        logic        err;
        logic [15:0] wrData;
        logic [7:0]  rdData;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          strobeLen;
        int          latency;
        int          acceptCycle;
        logic [15:0] dptrAfter;
    } expItem_t;

    expItem_t    expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [15:0] refDptr = {BB8051_RST_DPH, BB8051_RST_DPL};
    logic [7:0]  refRdData = 8'h00;
    int          respDelay = NEVER;
    logic [7:0]  respData = 8'h00;
    int          strobeCnt = 0;
    int          lastStrobeLen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory responder: acks in the respDelay-th strobe cycle, measures how
    // long each strobe stayed high, and sprinkles stray acks while idle
    initial begin
        xmemIf.xmem_ack   = 1'b0;
        xmemIf.xmem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (xmemIf.xmem_rd || xmemIf.xmem_wr) begin
                strobeCnt++;
                if (strobeCnt == respDelay) begin
                    xmemIf.xmem_ack   = 1'b1;
                    xmemIf.xmem_rdata = respData;
                end else begin
                    xmemIf.xmem_ack   = 1'b0;
                    xmemIf.xmem_rdata = 8'($urandom);
                end
            end else begin
                if (strobeCnt != 0) lastStrobeLen = strobeCnt;
                strobeCnt         = 0;
                xmemIf.xmem_ack   = ($urandom_range(0, 3) == 0);
                xmemIf.xmem_rdata = 8'($urandom);
            end
        end
    end

    // Scoreboard monitor: every done pulse is matched against the oldest
    // expected completion; the DPTR block is checked one cycle later
    initial begin
        expItem_t e;
        forever begin
            @(negedge clk);
            #1;
            if (o_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("done_pending", expQ.size(), 1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("err", o_err, e.err);
                    checkOutput("sfr_action", o_sfr_action,
                                e.isReg ? BB8051_SFR_ACT_WR_BYTE : BB8051_SFR_ACT_NONE);
                    checkOutput("rd_data", o_rd_data, e.rdData);
                    checkOutput("latency", cycleNo - e.acceptCycle, e.latency);
                    if (e.isReg) checkOutput("wr_data", {o_wr_data_h, o_wr_data_l}, e.wrData);
                    if (e.isXmem) begin
                        checkOutput("xmem_addr", xmemIf.xmem_addr, e.addr);
                        checkOutput("strobe_len", lastStrobeLen, e.strobeLen);
                        checkOutput("strobe_low", xmemIf.xmem_rd | xmemIf.xmem_wr, 0);
                    end
                    if (e.isWrite) checkOutput("xmem_wdata", xmemIf.xmem_wdata, e.wdata);
                    @(negedge clk);
                    #1;
                    checkOutput("dptr_after", dptrReg, e.dptrAfter);
                end
            end else begin
                if (o_sfr_action != BB8051_SFR_ACT_NONE) checkOutput("sfr_idle", o_sfr_action, BB8051_SFR_ACT_NONE);
                if (o_err) checkOutput("err_without_done", o_err, 0);
            end
        end
    end

    // Issue one command at a negedge once the sequencer is ready, after
    // predicting its outcome from the current DPTR and the memory delay
    task automatic applyStimulus(input logic [2:0] cmd, input logic [15:0] imm, input logic [7:0] acc,
                                 input int delay, input logic [7:0] data,
                                 input bit busyPulse, input bit expectDone);
        expItem_t    e;
        int          guard;
        logic [15:0] newDptr;
        logic [7:0]  newRd;
        guard = 0;
        while (o_cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (o_cmd_ready !== 1'b1) begin
            checkOutput("cmd_ready_wait", o_cmd_ready, 1);
            return;
        end
        respDelay = delay;
        respData  = data;

        e.isReg   = cmd inside {BB8051_DPC_LOAD16, BB8051_DPC_INC, BB8051_DPC_WR_DPH, BB8051_DPC_WR_DPL};
        e.isXmem  = cmd inside {BB8051_DPC_MOVX_RD, BB8051_DPC_MOVX_WR, BB8051_DPC_MOVC};
        e.isWrite = (cmd == BB8051_DPC_MOVX_WR);
        newDptr   = refDptr;
        newRd     = refRdData;
        case (cmd)
            BB8051_DPC_LOAD16: newDptr = imm;
            BB8051_DPC_INC:    newDptr = refDptr + 16'd1;
            BB8051_DPC_WR_DPH: newDptr = {imm[7:0], refDptr[7:0]};
            BB8051_DPC_WR_DPL: newDptr = {refDptr[15:8], imm[7:0]};
            default:           newDptr = refDptr;
        endcase
        e.addr  = (cmd == BB8051_DPC_MOVC) ? refDptr + {8'h00, acc} : refDptr;
        e.wdata = imm[7:0];
        e.err   = 1'b0;
        e.strobeLen = 0;
        if (e.isXmem) begin
            if (delay <= WAIT_MAX) begin
                e.strobeLen = delay;
                if (!e.isWrite) newRd = data;
            end else begin
                e.strobeLen = WAIT_MAX;
                e.err       = 1'b1;
                if (!e.isWrite) newRd = 8'hFF;
            end
        end
        e.latency     = e.strobeLen;
        e.wrData      = newDptr;
        e.dptrAfter   = newDptr;
        e.rdData      = newRd;
        e.acceptCycle = cycleNo + 1;
        if (expectDone) begin
            expQ.push_back(e);
            refDptr   = newDptr;
            refRdData = newRd;
        end

        i_cmd       = cmd;
        i_cmd_imm   = imm;
        i_acc       = acc;
        i_cmd_valid = 1'b1;
        @(negedge clk);
        if (busyPulse) begin
            i_cmd       = BB8051_DPC_LOAD16;
            i_cmd_imm   = 16'hDEAD;
            i_cmd_valid = 1'b1;
            @(negedge clk);
        end
        i_cmd_valid = 1'b0;
        i_cmd       = 3'($urandom);
        i_cmd_imm   = 16'($urandom);
    endtask

    initial begin
        int guard;
        int r;
        int delay;
        rst_n       = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd       = 3'd0;
        i_cmd_imm   = 16'h0000;
        i_acc       = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("reset_cmd_ready", o_cmd_ready, 1);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_sfr_action", o_sfr_action, BB8051_SFR_ACT_NONE);
        checkOutput("reset_wr_data", {o_wr_data_h, o_wr_data_l}, 16'h0000);
        checkOutput("reset_xmem", {xmemIf.xmem_addr, xmemIf.xmem_wdata, xmemIf.xmem_rd, xmemIf.xmem_wr}, 0);
        checkOutput("reset_rd_data", o_rd_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // INC with carry into DPH, then wrap from FFFF
        applyStimulus(BB8051_DPC_LOAD16, 16'h12FF, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_INC,    16'h0000, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_LOAD16, 16'hFFFF, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_INC,    16'h0000, 8'h00, NEVER, 8'h00, 0, 1);

        // Byte writes preserve the other byte
        applyStimulus(BB8051_DPC_LOAD16, 16'hABCD, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_WR_DPL, 16'h0055, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_WR_DPH, 16'h0066, 8'h00, NEVER, 8'h00, 0, 1);

        // MOVC with address wrap and ack in the third strobe cycle
        applyStimulus(BB8051_DPC_LOAD16, 16'hFFF0, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_MOVC,   16'h0000, 8'h20, 3, 8'h5A, 0, 1);

        // MOVX write that never gets acked
        applyStimulus(BB8051_DPC_LOAD16,  16'h4000, 8'h00, NEVER, 8'h00, 0, 1);
        applyStimulus(BB8051_DPC_MOVX_WR, 16'h0077, 8'h00, NEVER, 8'h00, 0, 1);

        // MOVX read acked in the first strobe cycle, with a command pulsed
        // while busy that must be dropped
        applyStimulus(BB8051_DPC_MOVX_RD, 16'h0000, 8'h00, 1, 8'hC3, 1, 1);

        // Ack exactly at the wait limit succeeds; one later times out
        applyStimulus(BB8051_DPC_MOVX_RD, 16'h0000, 8'h00, WAIT_MAX, 8'h81, 0, 1);
        applyStimulus(BB8051_DPC_MOVX_RD, 16'h0000, 8'h00, WAIT_MAX + 1, 8'h81, 0, 1);
        applyStimulus(BB8051_DPC_NOP,     16'h0000, 8'h00, NEVER, 8'h00, 1, 1);

        // Randomised mix of all commands and memory delays
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      delay = $urandom_range(1, 4);
            else if (r < 8) delay = $urandom_range(WAIT_MAX - 2, WAIT_MAX + 1);
            else            delay = NEVER;
            applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 8'($urandom), delay,
                          8'($urandom), ($urandom_range(0, 3) == 0), 1);
        end

        // Reset in the middle of a read transfer
        applyStimulus(BB8051_DPC_MOVX_RD, 16'h0000, 8'h00, NEVER, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("strobe_before_reset", xmemIf.xmem_rd, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_rd_strobe", xmemIf.xmem_rd, 0);
        checkOutput("reset_mid_done", {o_done, o_err}, 0);
        checkOutput("reset_mid_cmd_ready", o_cmd_ready, 1);
        checkOutput("reset_mid_addr", xmemIf.xmem_addr, 16'h0000);
        checkOutput("reset_mid_rd_data", o_rd_data, 8'h00);
        refDptr   = {BB8051_RST_DPH, BB8051_RST_DPL};
        refRdData = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", o_cmd_ready, 1);
        applyStimulus(BB8051_DPC_LOAD16, 16'h1234, 8'h00, NEVER, 8'h00, 0, 1);

        // Let the scoreboard drain
        guard = 0;
        while (expQ.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drain", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/bb8051_dptr_ctrl.md
Name: bb8051_dptr_ctrl

Overview:
- Sequencer in front of the DPTR register block. Takes single-cycle commands from the core decoder and turns each one into DPTR register writes (sfr_action / wr_data_h / wr_data_l).
- Also performs DPTR-addressed external memory transfers (MOVX @DPTR read and write, MOVC @A+DPTR read) over a req/ack bus with a bounded wait.
- This is the only writer of the DPTR register block.

Parameters:
- WAIT_MAX, 15: maximum cycles xmem strobe held without ack before abort (1..2^CNT_W-1).
- CNT_W, 4: wait-counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command strobe, sampled only when cmd_ready=1
- cmd  in  3  command code (see Decomposition)
- cmd_imm  in  16  immediate; [7:0] for byte commands and MOVX write data
- acc  in  8  accumulator, MOVC offset
- cmd_ready  out  1  high in IDLE only
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done on xmem timeout
- rd_data  out  8  last xmem read byte, held until next read completes
- dptr_in_h  in  8  current DPH from DPTR block
- dptr_in_l  in  8  current DPL from DPTR block
- sfr_action  out  2  to DPTR block
- wr_data_h  out  8  to DPTR block
- wr_data_l  out  8  to DPTR block
- xmem_addr  out  16  external address
- xmem_rd  out  1  read strobe, level until ack/timeout
- xmem_wr  out  1  write strobe, level until ack/timeout
- xmem_wdata  out  8  write data
- xmem_rdata  in  8  read data, valid with ack
- xmem_ack  in  1  transfer complete

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, sfr_action=BB8051_SFR_ACT_NONE.
  - wr_data_h/l, xmem_addr, xmem_wdata, rd_data all 0.
  - xmem_rd, xmem_wr, done, err all 0. Wait counter 0.
  - Strobes drop immediately even mid-transfer; no done is produced for the interrupted command.
- All outputs are registered. cmd_ready = (state==IDLE).
- States: IDLE, UPD, XREQ, FIN.
- IDLE, on cmd_valid (acceptance edge = E):
  - LOAD16, INC, WR_DPH, WR_DPL -> UPD.
  - MOVX_RD, MOVX_WR, MOVC -> XREQ.
  - NOP or an undefined code -> FIN.
- UPD (one cycle): sfr_action=WR_BYTE and wr_data valid; DPTR updates at edge E+1; done=1 in the same cycle; next state IDLE. Data per command:
  - LOAD16: wr_data = cmd_imm.
  - INC: wr_data = {dptr_in_h, dptr_in_l} + 1, modulo 2^16 (FFFF -> 0000).
  - WR_DPH: wr_data_h = cmd_imm[7:0], wr_data_l = dptr_in_l (the DPTR block writes both bytes, so the other byte is preserved).
  - WR_DPL: wr_data_h = dptr_in_h, wr_data_l = cmd_imm[7:0].
- XREQ:
  - xmem_addr is captured at E:
    - MOVX_RD, MOVX_WR: {dptr_in_h, dptr_in_l}.
    - MOVC: DPTR + {8'h00, acc}, modulo 2^16, carry discarded.
  - xmem_rd (MOVX_RD, MOVC) or xmem_wr (MOVX_WR) is high from cycle E+1.
  - xmem_ack is honoured in any XREQ cycle, including the first, so the minimum transfer is one cycle.
  - On ack: strobe low at the next edge; on a read, rd_data <= xmem_rdata; go to FIN.
  - No ack: the counter increments each cycle. When counter==WAIT_MAX with no ack, drop the strobe, set rd_data=8'hFF on reads (unchanged on writes), flag err, go to FIN.
  - Ack arriving on the same cycle the counter reaches WAIT_MAX counts as success.
- FIN (one cycle): done=1, err=1 if the transfer timed out; DPTR is never modified; next state IDLE.
- cmd_valid while cmd_ready=0 is ignored, not queued; the core holds the request.
- xmem_ack outside XREQ is ignored.
- sfr_action is WR_BYTE only in UPD; NONE otherwise.
- Throughput:
  - Register commands: 1 command per 2 cycles.
  - Xmem commands: 2 + wait cycles.

Decomposition:
- Shared defines include:
  - Existing BB8051_SFR_ACT_NONE / BB8051_SFR_ACT_WR_BYTE and BB8051_RST_DPH / BB8051_RST_DPL.
  - New cmd codes:
    - BB8051_DPC_NOP=0, LOAD16=1, INC=2, WR_DPH=3
    - WR_DPL=4, MOVX_RD=5, MOVX_WR=6, MOVC=7
  - State encodings for IDLE, UPD, XREQ, FIN.
- One natural sub-module: bb8051_dptr_addgen, a combinational 16-bit adder producing DPTR+1 and DPTR+acc, shared by INC and MOVC.

Test Plan:
- DPTR=0x12FF, INC -> next cycle sfr_action=WR_BYTE, wr_data=0x1300, done=1; DPTR=0x1300. Repeat from 0xFFFF -> 0x0000.
- DPTR=0xABCD, WR_DPL imm=0x55 -> wr_data_h=0xAB, wr_data_l=0x55. Then WR_DPH imm=0x66 -> DPTR=0x6655.
- DPTR=0xFFF0, acc=0x20, MOVC, ack after 3 cycles with rdata=0x5A -> xmem_addr=0x0010, xmem_rd high 3 cycles, rd_data=0x5A, done without err.
- MOVX_WR imm=0x77, DPTR=0x4000, ack never asserted, WAIT_MAX=15:
  - xmem_wr high 15 cycles, then low.
  - done=err=1 one cycle; rd_data unchanged; DPTR unchanged.
- MOVX_RD with ack in the first strobe cycle -> done 2 cycles after acceptance. cmd_valid pulsed while busy -> ignored, no second transfer.
- Assert rst low mid-XREQ -> xmem_rd low immediately, all outputs at reset values, no done. After release, cmd_ready=1 and a LOAD16 0x1234 completes normally.
